dma_read_src_fsm: RTL and testbench

Source-read stage of the DMA datapath. It takes a descriptor (source address and beat count) and splits it into AXI4 INCR read bursts. Each returned beat is pushed into the shared DMA data FIFO. The downstream write-destination FSM drains that FIFO to the destination memory. Before issuing each read, the block reserves FIFO space for the whole burst, so it never needs to backpressure the AXI R channel mid-burst.

---
 rtl/dma_read_src_fsm.sv | 262 ++++++++++++++++++++++++++
 tb/tb_dma_read_src_fsm.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_read_src_fsm.sv
// -----------------------------------------------------------------------------
// dma_read_src_fsm
//
// Source-read stage of the DMA datapath. A descriptor (source byte address and
// total beat count) is split into AXI4 INCR read bursts of at most MAX_BURST
// beats. FIFO space for a whole burst is reserved before its AR is issued, so
// rready never drops in the middle of a burst. Every accepted R beat is pushed
// into the shared DMA data FIFO one cycle after its handshake.
//
// Ports
//   clk, reset         clock; asynchronous active-high reset
//   go, src_addr,      descriptor start (sampled in IDLE only)
//   length
//   clear_err          leave ERROR and return to IDLE
//   busy               high in every state except IDLE
//   rd_fsm_done        one-cycle completion pulse (aligned with last FIFO write)
//   err, err_code      error flag; err_code[1:0] = first bad rresp,
//                      err_code[2] = beat-count / rlast mismatch
//   ar*                AXI4 read-address channel (master side)
//   r*                 AXI4 read-data channel (master side)
//   fifo_wr_en/_data   push into the DMA data FIFO
//   fifo_free          free entries currently available in that FIFO
//
// Build option
//   DMA_RD_BEAT_CHECK_EN  when defined, the burst ends when the beat counter
//                         reaches the burst length and any rlast disagreement
//                         sets err_code[2]; when undefined, rlast alone ends
//                         the burst and err_code[2] stays 0.
// -----------------------------------------------------------------------------
module dma_read_src_fsm #(
    parameter int DATA_W    = 512,
    parameter int ADDR_W    = 64,
    parameter int MAX_BURST = 64,
    parameter int FREE_W    = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [31:0]       length,
    input  logic              clear_err,
    output logic              busy,
    output logic              rd_fsm_done,
    output logic              err,
    output logic [2:0]        err_code,
    output logic              arvalid,
    input  logic              arready,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    input  logic              rvalid,
    output logic              rready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_wr_data,
    input  logic [FREE_W-1:0] fifo_free
);

    localparam int         SIZE_LOG2 = $clog2(DATA_W / 8);
    localparam logic [2:0] AXSIZE    = 3'(SIZE_LOG2);
    localparam logic [8:0] MAX_BEATS = 9'(MAX_BURST);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR_SETUP,
        S_RD_DATA,
        S_ERROR
    } state_t;

    state_t              state_q;
    // ADDR_SETUP runs in two steps: step 0 sizes the burst and loads the AR
    // fields, step 1 waits for FIFO credit and then for arready.
    logic                setup_phase_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         remaining_q;
    logic [8:0]          beats_q;
    logic                resp_err_q;

    logic                busy_q;
    logic                done_q;
    logic                err_q;
    logic [2:0]          err_code_q;
    logic                arvalid_q;
    logic [ADDR_W-1:0]   araddr_q;
    logic [7:0]          arlen_q;
    logic [2:0]          arsize_q;
    logic [1:0]          arburst_q;
    logic                rready_q;
    logic                fifo_wr_en_q;
    logic [DATA_W-1:0]   fifo_wr_data_q;

    logic [8:0]          beats_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [31:0]         remaining_d;
    logic                credit_ok;
    logic                r_hs;
    logic                resp_bad;
    logic                burst_end;
    logic                len_err;
    logic                err_any;

    assign beats_d     = (remaining_q < 32'(MAX_BURST)) ? remaining_q[8:0] : MAX_BEATS;
    // Bursts never cross 4 KB because the source address is burst-aligned,
    // so a plain add (wrapping at 2^ADDR_W) is enough.
    assign addr_d      = addr_q + (ADDR_W'(beats_q) << SIZE_LOG2);
    assign remaining_d = remaining_q - 32'(beats_q);
    assign credit_ok   = (32'(fifo_free) >= 32'(beats_q));
    assign r_hs        = rvalid & rready_q;
    assign resp_bad    = r_hs & rresp[1];

`ifdef DMA_RD_BEAT_CHECK_EN
    logic [8:0] beat_cnt_q;
    logic       last_beat;

    assign last_beat = (beat_cnt_q == (beats_q - 9'd1));
    // Stop at the expected last beat or at any rlast, whichever comes first;
    // a disagreement between the two is a length error.
    assign burst_end = r_hs & (rlast | last_beat);
    assign len_err   = r_hs & (rlast != last_beat);
`else
    assign burst_end = r_hs & rlast;
    assign len_err   = 1'b0;
`endif

    assign err_any = resp_err_q | resp_bad | len_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            setup_phase_q  <= 1'b0;
            addr_q         <= '0;
            remaining_q    <= '0;
            beats_q        <= '0;
            resp_err_q     <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            err_code_q     <= '0;
            arvalid_q      <= 1'b0;
            araddr_q       <= '0;
            arlen_q        <= '0;
            arsize_q       <= '0;
            arburst_q      <= '0;
            rready_q       <= 1'b0;
            fifo_wr_en_q   <= 1'b0;
            fifo_wr_data_q <= '0;
`ifdef DMA_RD_BEAT_CHECK_EN
            beat_cnt_q     <= '0;
`endif
        end else begin
            done_q       <= 1'b0;
            fifo_wr_en_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (go) begin
                        if (length == 32'd0) begin
                            // Empty descriptor: complete without touching AXI.
                            done_q <= 1'b1;
                        end else begin
                            state_q       <= S_ADDR_SETUP;
                            setup_phase_q <= 1'b0;
                            busy_q        <= 1'b1;
                            addr_q        <= src_addr;
                            remaining_q   <= length;
                            resp_err_q    <= 1'b0;
                        end
                    end
                end

                S_ADDR_SETUP: begin
                    if (!setup_phase_q) begin
                        beats_q       <= beats_d;
                        araddr_q      <= addr_q;
                        arlen_q       <= 8'(beats_d - 9'd1);
                        arsize_q      <= AXSIZE;
                        arburst_q     <= 2'b01;
                        setup_phase_q <= 1'b1;
                    end else if (!arvalid_q) begin
                        // Reserve room for the whole burst before asking for it.
                        if (credit_ok) begin
                            arvalid_q <= 1'b1;
                        end
                    end else if (arready) begin
                        arvalid_q   <= 1'b0;
                        rready_q    <= 1'b1;
                        addr_q      <= addr_d;
                        remaining_q <= remaining_d;
                        state_q     <= S_RD_DATA;
`ifdef DMA_RD_BEAT_CHECK_EN
                        beat_cnt_q  <= '0;
`endif
                    end
                end

                S_RD_DATA: begin
                    if (r_hs) begin
                        // Errored beats are still forwarded; only the first
                        // bad response code is kept.
                        fifo_wr_en_q   <= 1'b1;
                        fifo_wr_data_q <= rdata;
                        if (resp_bad && !resp_err_q) begin
                            resp_err_q      <= 1'b1;
                            err_code_q[1:0] <= rresp;
                        end
`ifdef DMA_RD_BEAT_CHECK_EN
                        beat_cnt_q <= beat_cnt_q + 9'd1;
                        if (len_err) begin
                            err_code_q[2] <= 1'b1;
                        end
`endif
                        if (burst_end) begin
                            rready_q <= 1'b0;
                            if (err_any) begin
                                state_q <= S_ERROR;
                                err_q   <= 1'b1;
                            end else if (remaining_q != 32'd0) begin
                                state_q       <= S_ADDR_SETUP;
                                setup_phase_q <= 1'b0;
                            end else begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                end

                S_ERROR: begin
                    if (clear_err) begin
                        state_q    <= S_IDLE;
                        busy_q     <= 1'b0;
                        err_q      <= 1'b0;
                        err_code_q <= '0;
                        resp_err_q <= 1'b0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign rd_fsm_done  = done_q;
    assign err          = err_q;
    assign err_code     = err_code_q;
    assign arvalid      = arvalid_q;
    assign araddr       = araddr_q;
    assign arlen        = arlen_q;
    assign arsize       = arsize_q;
    assign arburst      = arburst_q;
    assign rready       = rready_q;
    assign fifo_wr_en   = fifo_wr_en_q;
    assign fifo_wr_data = fifo_wr_data_q;

endmodule

// File: tb/tb_dma_read_src_fsm.sv
module tb_dma_read_src_fsm;

    localparam int DATA_W    = 512;
    localparam int ADDR_W    = 64;
    localparam int MAX_BURST = 64;
    localparam int FREE_W    = 10;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              go = 1'b0;
    logic [ADDR_W-1:0] src_addr = '0;
    logic [31:0]       length = '0;
    logic              clear_err = 1'b0;
    logic              busy;
    logic              rd_fsm_done;
    logic              err;
    logic [2:0]        err_code;
    logic              arvalid;
    logic              arready = 1'b0;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              rvalid = 1'b0;
    logic              rready;
    logic [DATA_W-1:0] rdata = '0;
    logic [1:0]        rresp = 2'b00;
    logic              rlast = 1'b0;
    logic              fifo_wr_en;
    logic [DATA_W-1:0] fifo_wr_data;
    logic [FREE_W-1:0] fifo_free = 10'd512;

    dma_read_src_fsm #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .MAX_BURST(MAX_BURST),
        .FREE_W   (FREE_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .go          (go),
        .src_addr    (src_addr),
        .length      (length),
        .clear_err   (clear_err),
        .busy        (busy),
        .rd_fsm_done (rd_fsm_done),
        .err         (err),
        .err_code    (err_code),
        .arvalid     (arvalid),
        .arready     (arready),
        .araddr      (araddr),
        .arlen       (arlen),
        .arsize      (arsize),
        .arburst     (arburst),
        .rvalid      (rvalid),
        .rready      (rready),
        .rdata       (rdata),
        .rresp       (rresp),
        .rlast       (rlast),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_wr_data(fifo_wr_data),
        .fifo_free   (fifo_free)
    );

    always #5 clk = ~clk;

    int vec = 0;
    int errs = 0;
    int sent_total = 0;

    // Observation logs, sampled on the falling edge.
    int                done_cnt = 0;
    logic              done_wr = 1'b0;
    logic [DATA_W-1:0] wr_q[$];
    logic [ADDR_W-1:0] ar_addr_q[$];
    logic [7:0]        ar_len_q[$];
    logic [4:0]        ar_attr_q[$];

    always @(negedge clk) begin
        if (fifo_wr_en) wr_q.push_back(fifo_wr_data);
        if (arvalid && arready) begin
            ar_addr_q.push_back(araddr);
            ar_len_q.push_back(arlen);
            ar_attr_q.push_back({arsize, arburst});
        end
        if (rd_fsm_done) begin
            done_cnt <= done_cnt + 1;
            done_wr  <= fifo_wr_en;
        end
    end

    function automatic logic [DATA_W-1:0] pat(input int n);
        logic [31:0] w;
        w = n;
        w = w ^ 32'h5A5A_0000;
        return {16{w}};
    endfunction

    // AXI slave: arready high, beats returned back to back while rready is high.
    task automatic serve(input int max_cyc, input int err_beat, input int err_beat2,
                         input int last_beat, output int first_ar, output bit ok);
        int beats_left;
        beats_left = 0;
        first_ar = -1;
        ok = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            @(posedge clk); #1;
            go = 1'b0;
            if (rd_fsm_done || err) begin
                ok = 1'b1;
                break;
            end
            arready = 1'b1;
            if (arvalid && first_ar < 0) first_ar = c;
            if (arvalid) beats_left += int'(arlen) + 1;
            if (rready && beats_left > 0) begin
                rvalid = 1'b1;
                rdata  = pat(sent_total);
                rresp  = (sent_total == err_beat)  ? 2'b10 :
                         (sent_total == err_beat2) ? 2'b11 : 2'b00;
                rlast  = (beats_left == 1) || (sent_total == last_beat);
                beats_left = rlast ? 0 : beats_left - 1;
                sent_total++;
            end else begin
                rvalid = 1'b0;
                rlast  = 1'b0;
                rresp  = 2'b00;
            end
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vec++;
        if ({busy, rd_fsm_done, err, err_code, arvalid, rready, fifo_wr_en} !== 9'd0) begin
            errs++;
            $display("FAIL reset_ctrl: got %b required 0", {busy, rd_fsm_done, err, err_code, arvalid, rready, fifo_wr_en});
        end
        vec++;
        if ({araddr, arlen, arsize, arburst} !== 77'd0) begin
            errs++;
            $display("FAIL reset_ar: got %h required 0", {araddr, arlen, arsize, arburst});
        end
        vec++;
        if (fifo_wr_data !== '0) begin
            errs++;
            $display("FAIL reset_wdata: got %h required 0", fifo_wr_data);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        vec++;
        if (busy !== 1'b0) begin
            errs++;
            $display("FAIL reset_release_busy: got %b required 0", busy);
        end
    endtask

    task automatic test_single_burst();
        int w0, a0, d0, b0, far;
        bit ok;
        w0 = wr_q.size(); a0 = ar_addr_q.size(); d0 = done_cnt; b0 = sent_total;
        src_addr = 64'h1000; length = 32'd4; fifo_free = 10'd512; go = 1'b1;
        serve(60, -1, -1, -1, far, ok);
        @(negedge clk); #1;
        vec++;
        if (!ok) begin errs++; $display("FAIL single_timeout: got no completion required done"); end
        vec++;
        if (far !== 2) begin errs++; $display("FAIL single_ar_latency: got %0d required 2", far); end
        vec++;
        if (ar_addr_q.size() - a0 !== 1) begin
            errs++; $display("FAIL single_ar_count: got %0d required 1", ar_addr_q.size() - a0);
        end
        if (ar_addr_q.size() > a0) begin
            vec++;
            if (ar_addr_q[a0] !== 64'h1000) begin errs++; $display("FAIL single_araddr: got %h required 1000", ar_addr_q[a0]); end
            vec++;
            if (ar_len_q[a0] !== 8'd3) begin errs++; $display("FAIL single_arlen: got %0d required 3", ar_len_q[a0]); end
            vec++;
            if (ar_attr_q[a0] !== 5'b110_01) begin errs++; $display("FAIL single_arsize_burst: got %b required 11001", ar_attr_q[a0]); end
        end
        vec++;
        if (wr_q.size() - w0 !== 4) begin errs++; $display("FAIL single_wr_count: got %0d required 4", wr_q.size() - w0); end
        for (int i = 0; i < 4; i++) begin
            if (wr_q.size() > w0 + i) begin
                vec++;
                if (wr_q[w0+i] !== pat(b0 + i)) begin
                    errs++; $display("FAIL single_data%0d: got %h required %h", i, wr_q[w0+i][31:0], pat(b0+i)[31:0]);
                end
            end
        end
        vec++;
        if (done_cnt - d0 !== 1) begin errs++; $display("FAIL single_done_count: got %0d required 1", done_cnt - d0); end
        vec++;
        if (done_wr !== 1'b1) begin errs++; $display("FAIL single_done_align: got %b required 1", done_wr); end
        vec++;
        if (busy !== 1'b0) begin errs++; $display("FAIL single_busy_end: got %b required 0", busy); end
    endtask

    task automatic test_zero_length();
        int a0;
        a0 = ar_addr_q.size();
        src_addr = 64'h5000; length = 32'd0; go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        vec++;
        if (rd_fsm_done !== 1'b1) begin errs++; $display("FAIL zero_done: got %b required 1", rd_fsm_done); end
        vec++;
        if (busy !== 1'b0) begin errs++; $display("FAIL zero_busy: got %b required 0", busy); end
        @(posedge clk); #1;
        vec++;
        if (rd_fsm_done !== 1'b0) begin errs++; $display("FAIL zero_done_pulse: got %b required 0", rd_fsm_done); end
        repeat (3) @(posedge clk);
        #1;
        vec++;
        if (ar_addr_q.size() != a0 || arvalid !== 1'b0) begin
            errs++; $display("FAIL zero_no_ar: got %0d ARs arvalid=%b required 0 ARs", ar_addr_q.size() - a0, arvalid);
        end
    endtask

    task automatic test_split();
        int w0, a0, d0, b0, far;
        bit ok;
        logic [ADDR_W-1:0] exp_addr[3];
        logic [7:0]        exp_len[3];
        exp_addr[0] = 64'h0;    exp_len[0] = 8'd63;
        exp_addr[1] = 64'h1000; exp_len[1] = 8'd63;
        exp_addr[2] = 64'h2000; exp_len[2] = 8'd1;
        w0 = wr_q.size(); a0 = ar_addr_q.size(); d0 = done_cnt; b0 = sent_total;
        src_addr = 64'h0; length = 32'd130; go = 1'b1;
        serve(600, -1, -1, -1, far, ok);
        @(negedge clk); #1;
        vec++;
        if (!ok) begin errs++; $display("FAIL split_timeout: got no completion required done"); end
        vec++;
        if (ar_addr_q.size() - a0 !== 3) begin errs++; $display("FAIL split_ar_count: got %0d required 3", ar_addr_q.size() - a0); end
        for (int i = 0; i < 3; i++) begin
            if (ar_addr_q.size() > a0 + i) begin
                vec++;
                if (ar_addr_q[a0+i] !== exp_addr[i] || ar_len_q[a0+i] !== exp_len[i]) begin
                    errs++; $display("FAIL split_ar%0d: got (%h,%0d) required (%h,%0d)", i, ar_addr_q[a0+i], ar_len_q[a0+i], exp_addr[i], exp_len[i]);
                end
            end
        end
        vec++;
        if (wr_q.size() - w0 !== 130) begin errs++; $display("FAIL split_wr_count: got %0d required 130", wr_q.size() - w0); end
        if (wr_q.size() >= w0 + 130) begin
            vec++;
            if (wr_q[w0+64] !== pat(b0 + 64) || wr_q[w0+129] !== pat(b0 + 129)) begin
                errs++; $display("FAIL split_data: got %h/%h required %h/%h", wr_q[w0+64][31:0], wr_q[w0+129][31:0], pat(b0+64)[31:0], pat(b0+129)[31:0]);
            end
        end
        vec++;
        if (done_cnt - d0 !== 1) begin errs++; $display("FAIL split_done_count: got %0d required 1", done_cnt - d0); end
    endtask

    task automatic test_credit_stall();
        int w0, d0, far, lat;
        bit ok, seen;
        w0 = wr_q.size(); d0 = done_cnt;
        arready = 1'b0; fifo_free = 10'd10;
        src_addr = 64'h10000; length = 32'd64; go = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            go = 1'b0;
            if (arvalid) seen = 1'b1;
        end
        vec++;
        if (seen !== 1'b0 || busy !== 1'b1) begin errs++; $display("FAIL credit_stall10: got arvalid_seen=%b busy=%b required 0/1", seen, busy); end
        fifo_free = 10'd63;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (arvalid) seen = 1'b1;
        end
        vec++;
        if (seen !== 1'b0) begin errs++; $display("FAIL credit_stall63: got arvalid_seen=%b required 0", seen); end
        fifo_free = 10'd64;
        lat = -1;
        for (int c = 1; c <= 2; c++) begin
            @(posedge clk); #1;
            if (arvalid && lat < 0) lat = c;
        end
        vec++;
        if (lat < 0) begin errs++; $display("FAIL credit_release: got arvalid=0 after 2 cycles required 1"); end
        serve(200, -1, -1, -1, far, ok);
        @(negedge clk); #1;
        vec++;
        if (!ok || wr_q.size() - w0 !== 64 || done_cnt - d0 !== 1) begin
            errs++; $display("FAIL credit_complete: got ok=%b writes=%0d dones=%0d required 1/64/1", ok, wr_q.size() - w0, done_cnt - d0);
        end
        fifo_free = 10'd512;
    endtask

    task automatic test_ar_hold();
        int w0, far;
        bit ok, stable;
        w0 = wr_q.size();
        arready = 1'b0;
        src_addr = 64'h20000; length = 32'd8; go = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            go = 1'b0;
            if (arvalid) break;
        end
        vec++;
        if (arvalid !== 1'b1) begin errs++; $display("FAIL hold_arvalid: got %b required 1", arvalid); end
        stable = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (arvalid !== 1'b1 || araddr !== 64'h20000 || arlen !== 8'd7) stable = 1'b0;
        end
        vec++;
        if (stable !== 1'b1) begin errs++; $display("FAIL hold_stable: got arvalid=%b araddr=%h arlen=%0d required 1/20000/7", arvalid, araddr, arlen); end
        serve(100, -1, -1, -1, far, ok);
        @(negedge clk); #1;
        vec++;
        if (!ok || wr_q.size() - w0 !== 8) begin errs++; $display("FAIL hold_complete: got ok=%b writes=%0d required 1/8", ok, wr_q.size() - w0); end
    endtask

    task automatic test_resp_err();
        int w0, a0, d0, b0, far;
        bit ok, ar_seen;
        w0 = wr_q.size(); d0 = done_cnt; b0 = sent_total;
        src_addr = 64'h3000; length = 32'd4; go = 1'b1;
        serve(60, b0 + 1, b0 + 3, -1, far, ok);
        @(negedge clk); #1;
        vec++;
        if (!ok) begin errs++; $display("FAIL resp_timeout: got no end required err"); end
        vec++;
        if (wr_q.size() - w0 !== 4) begin errs++; $display("FAIL resp_wr_count: got %0d required 4", wr_q.size() - w0); end
        if (wr_q.size() > w0 + 1) begin
            vec++;
            if (wr_q[w0+1] !== pat(b0 + 1)) begin errs++; $display("FAIL resp_err_beat_data: got %h required %h", wr_q[w0+1][31:0], pat(b0+1)[31:0]); end
        end
        vec++;
        if (err !== 1'b1 || err_code !== 3'b010) begin errs++; $display("FAIL resp_err_code: got err=%b code=%b required 1/010", err, err_code); end
        vec++;
        if (done_cnt - d0 !== 0 || busy !== 1'b1 || rready !== 1'b0) begin
            errs++; $display("FAIL resp_state: got dones=%0d busy=%b rready=%b required 0/1/0", done_cnt - d0, busy, rready);
        end
        a0 = ar_addr_q.size();
        length = 32'd4; go = 1'b1;
        ar_seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            go = 1'b0;
            if (arvalid) ar_seen = 1'b1;
        end
        vec++;
        if (ar_seen !== 1'b0 || ar_addr_q.size() != a0 || err !== 1'b1) begin
            errs++; $display("FAIL resp_go_ignored: got arvalid_seen=%b err=%b required 0/1", ar_seen, err);
        end
        clear_err = 1'b1;
        @(posedge clk); #1;
        clear_err = 1'b0;
        vec++;
        if (err !== 1'b0 || err_code !== 3'b000 || busy !== 1'b0) begin
            errs++; $display("FAIL resp_clear: got err=%b code=%b busy=%b required 0/000/0", err, err_code, busy);
        end
    endtask

    task automatic test_beat_check();
        int w0, d0, b0, far;
        bit ok;
        w0 = wr_q.size(); d0 = done_cnt; b0 = sent_total;
        src_addr = 64'h4000; length = 32'd4; go = 1'b1;
        serve(60, -1, -1, b0 + 2, far, ok);
        @(negedge clk); #1;
        vec++;
        if (!ok || wr_q.size() - w0 !== 3) begin errs++; $display("FAIL beat_writes: got ok=%b writes=%0d required 1/3", ok, wr_q.size() - w0); end
`ifdef DMA_RD_BEAT_CHECK_EN
        vec++;
        if (err !== 1'b1 || err_code !== 3'b100 || rready !== 1'b0 || done_cnt - d0 !== 0) begin
            errs++; $display("FAIL beat_check_err: got err=%b code=%b rready=%b dones=%0d required 1/100/0/0", err, err_code, rready, done_cnt - d0);
        end
        clear_err = 1'b1;
        @(posedge clk); #1;
        clear_err = 1'b0;
`else
        vec++;
        if (err !== 1'b0 || err_code !== 3'b000 || done_cnt - d0 !== 1 || busy !== 1'b0) begin
            errs++; $display("FAIL beat_rlast_end: got err=%b code=%b dones=%0d busy=%b required 0/000/1/0", err, err_code, done_cnt - d0, busy);
        end
`endif
    endtask

    task automatic test_reset_mid();
        arready = 1'b1;
        src_addr = 64'h30000; length = 32'd16; go = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            go = 1'b0;
            if (rready) break;
        end
        vec++;
        if (rready !== 1'b1) begin errs++; $display("FAIL midrst_rready: got %b required 1", rready); end
        for (int i = 0; i < 2; i++) begin
            rvalid = 1'b1; rdata = pat(sent_total); rresp = 2'b00; rlast = 1'b0;
            sent_total++;
            @(posedge clk); #1;
        end
        vec++;
        if (fifo_wr_en !== 1'b1 || busy !== 1'b1) begin errs++; $display("FAIL midrst_pre: got wr_en=%b busy=%b required 1/1", fifo_wr_en, busy); end
        #2 reset = 1'b1;
        #1;
        vec++;
        if ({busy, rd_fsm_done, err, err_code, arvalid, rready, fifo_wr_en} !== 9'd0) begin
            errs++; $display("FAIL midrst_ctrl: got %b required 0", {busy, rd_fsm_done, err, err_code, arvalid, rready, fifo_wr_en});
        end
        vec++;
        if ({araddr, arlen, arsize, arburst} !== 77'd0) begin
            errs++; $display("FAIL midrst_ar: got %h required 0", {araddr, arlen, arsize, arburst});
        end
        vec++;
        if (fifo_wr_data !== '0) begin errs++; $display("FAIL midrst_wdata: got %h required 0", fifo_wr_data); end
        rvalid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        vec++;
        if (busy !== 1'b0 || rready !== 1'b0) begin errs++; $display("FAIL midrst_after: got busy=%b rready=%b required 0/0", busy, rready); end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_zero_length();
        test_split();
        test_credit_stall();
        test_ar_hold();
        test_resp_err();
        test_beat_check();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
